ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
Parametrised successor to the single-key PS/2 front end. Consumes raw scan-code bytes from the PS/2 byte receiver and decodes make/break/extended (E0) sequences. Tracks the held key, counts presses with configurable typematic-repeat handling, and queues decoded key events in a FIFO with a valid/ready handshake. Sits between the PS/2 receiver and the display/ASCII logic; the `key`, `is_press` and `count` outputs drive the seven-segment path directly.

Parameters:
COUNT_W, 8, width of the press counter; wraps modulo 2^COUNT_W.
FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
COUNT_REPEAT, 0, 0 = typematic repeats of the held key are suppressed; 1 = every make counts and is queued.

Ports:
clk  in  1  system clock, all logic rising-edge.
rst  in  1  synchronous, active-low reset; sampled on the clk edge, rst=0 resets.
in_valid  in  1  in_data holds one received scan byte this cycle; a byte is accepted every cycle in_valid=1.
in_data  in  8  scan-code byte.
out_valid  out  1  FIFO head holds an event.
out_ready  in  1  consumer takes the head event when out_valid & out_ready.
out_key  out  8  head event scan code.
out_ext  out  1  head event had an E0 prefix.
out_make  out  1  head event type: 1 = make, 0 = break.
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued events.
overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
key  out  8  code of the currently held key; 0x00 when none is held.
is_ext  out  1  held key is extended.
is_press  out  1  1 while a key is held, i.e. key != 0x00.
count  out  COUNT_W  number of counted presses.

Behaviour:
- Reset (rst=0 at an edge): decoder in IDLE, FIFO empty, out_valid=0, fifo_level=0, overflow=0, key=0x00, is_ext=0, is_press=0, count=0. Reset overrides a simultaneous in_valid and out_ready; a partial sequence is discarded.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK. Per accepted byte:
  - 0x00 or 0xFF in any state: go to IDLE, no event.
  - 0xE0 in any state: go to EXT. A partial prefix is discarded.
  - 0xF0 in IDLE or BRK: go to BRK.
  - 0xF0 in EXT or EXT_BRK: go to EXT_BRK.
  - Any other byte C: emit an event, then go to IDLE.
    - from IDLE: make, ext=0.
    - from EXT: make, ext=1.
    - from BRK: break, ext=0.
    - from EXT_BRK: break, ext=1.
- Event handling, updated on the edge that accepts the final byte (latency 1: the effect is visible in the cycle after in_valid):
  - Make, {C,ext} != held key: key=C, is_ext=ext, count+1, event queued.
  - Make, {C,ext} == held key (repeat):
    - COUNT_REPEAT=0: nothing changes, nothing queued.
    - COUNT_REPEAT=1: count+1, event queued.
  - Break matching the held key: key=0x00, is_ext=0, event queued.
  - Break not matching the held key: held state unchanged, event queued.
- count wraps from 2^COUNT_W-1 to 0. No saturation.
- FIFO ordering and timing:
  - First-in first-out.
  - The head is stable while out_valid=1 and out_ready=0.
  - out_valid rises the cycle after a write into an empty FIFO. There is no fall-through in the same cycle.
- Pop rule: pop when out_valid & out_ready. When out_valid=0, out_key, out_ext and out_make are don't-care.
- Simultaneous push and pop:
  - When not full: level unchanged.
  - When full: the pop frees a slot and the push is accepted, no overflow.
- Push when full without a pop: the event is dropped and overflow is set to 1. overflow clears only on reset. key, is_ext and count still update.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges from 0 to FIFO_DEPTH.

Test Plan:
- Plain press/release: bytes 1C, F0, 1C; out_ready=1 -> events (1C, make, ext0) then (1C, break, ext0). key=0x1C then 0x00, is_press 1 then 0, count=1.
- Extended key: bytes E0 75, E0 F0 75 -> events (75, make, ext1) and (75, break, ext1). is_ext=1 while held. count=1.
- Typematic repeat: bytes 1C x5, COUNT_REPEAT=0 -> count=1, one event. Same stimulus with COUNT_REPEAT=1 -> count=5, five events.
- Overflow: FIFO_DEPTH=8, out_ready=0, nine makes of distinct codes 15..1D -> fifo_level=8, overflow=1. Draining yields 15..1C in order and 1D is lost. key=0x1D, count=9.
- Count wrap: COUNT_W=4, 17 press/release pairs of distinct keys -> count=1. Push with pop while full -> no overflow, level stays 8.
- Reset mid-sequence: bytes E0 F0, then rst=0 for one cycle, then byte 75 -> single event (75, make, ext0). All outputs hold their reset values during reset.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// Scan-byte input and decoded-event output handshake of the PS/2 key tracker.
// The tracker attaches through the slave modport.
interface ps2_key_tracker_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_key;
    logic       out_ext;
    logic       out_make;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_key, out_ext, out_make
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_key, out_ext, out_make
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder: make/break/E0 sequencing, held-key tracking, press counting
// and an event FIFO with a valid/ready output.
module ps2_key_tracker #(
    parameter int unsigned COUNT_W      = 8,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter bit          COUNT_REPEAT = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    ps2_key_tracker_if.slave            bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic [7:0]                  key,
    output logic                        is_ext,
    output logic                        is_press,
    output logic [COUNT_W-1:0]          count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e             state_q, state_d;
    logic [7:0]         key_q, key_d;
    logic               is_ext_q, is_ext_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]      level_q, level_d;
    logic               overflow_q;
    logic [9:0]         mem [FIFO_DEPTH];

    logic ev_valid, ev_make, ev_ext, held_match;
    logic push, pop, full, push_ok, drop;

    // Byte-level decode; an event is any non-prefix, non-reset code.
    always_comb begin
        state_d  = state_q;
        ev_valid = 1'b0;
        ev_make  = (state_q == StIdle) || (state_q == StExt);
        ev_ext   = (state_q == StExt) || (state_q == StExtBrk);
        if (bus.in_valid) begin
            if (bus.in_data == 8'h00 || bus.in_data == 8'hFF) begin
                state_d = StIdle;
            end else if (bus.in_data == 8'hE0) begin
                state_d = StExt;
            end else if (bus.in_data == 8'hF0) begin
                state_d = ev_ext ? StExtBrk : StBrk;
            end else begin
                ev_valid = 1'b1;
                state_d  = StIdle;
            end
        end
    end

    assign held_match = (key_q == bus.in_data) && (is_ext_q == ev_ext);

    always_comb begin
        key_d    = key_q;
        is_ext_d = is_ext_q;
        count_d  = count_q;
        push     = 1'b0;
        if (ev_valid) begin
            if (ev_make) begin
                if (!held_match) begin
                    key_d    = bus.in_data;
                    is_ext_d = ev_ext;
                    count_d  = count_q + COUNT_W'(1);
                    push     = 1'b1;
                end else if (COUNT_REPEAT) begin
                    count_d = count_q + COUNT_W'(1);
                    push    = 1'b1;
                end
            end else begin
                push = 1'b1;
                if (held_match) begin
                    key_d    = 8'h00;
                    is_ext_d = 1'b0;
                end
            end
        end
    end

    // A pop frees the slot a same-cycle push needs, so full only blocks an unpaired push.
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign pop     = bus.out_valid && bus.out_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            key_q      <= 8'h00;
            is_ext_q   <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            is_ext_q <= is_ext_d;
            count_q  <= count_d;
            level_q  <= level_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_ptr_q] <= {ev_make, ev_ext, bus.in_data};
        end
    end

    assign bus.out_valid = (level_q != '0);
    assign bus.out_key   = mem[rd_ptr_q][7:0];
    assign bus.out_ext   = mem[rd_ptr_q][8];
    assign bus.out_make  = mem[rd_ptr_q][9];

    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign key        = key_q;
    assign is_ext     = is_ext_q;
    assign is_press   = (key_q != 8'h00);
    assign count      = count_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench: two trackers (4-bit count without repeats, 8-bit count with repeats)
// share one stimulus stream and are checked against hand-computed values.
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    ps2_key_tracker_if bus_a ();
    ps2_key_tracker_if bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.out_ready = out_ready;

    logic [3:0] level_a, level_b;
    logic       ovf_a, ovf_b, ext_a, ext_b, press_a, press_b;
    logic [7:0] key_a, key_b;
    logic [3:0] count_a;
    logic [7:0] count_b;

    ps2_key_tracker #(.COUNT_W(4), .FIFO_DEPTH(8), .COUNT_REPEAT(1'b0)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_a),
        .fifo_level (level_a),
        .overflow   (ovf_a),
        .key        (key_a),
        .is_ext     (ext_a),
        .is_press   (press_a),
        .count      (count_a)
    );

    ps2_key_tracker #(.COUNT_W(8), .FIFO_DEPTH(8), .COUNT_REPEAT(1'b1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_b),
        .fifo_level (level_b),
        .overflow   (ovf_b),
        .key        (key_b),
        .is_ext     (ext_b),
        .is_press   (press_b),
        .count      (count_b)
    );

    int unsigned drain_key  [8] = '{'h16, 'h17, 'h18, 'h19, 'h1A, 'h1B, 'h1C, 'h1C};
    int unsigned drain_make [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_held(input string tag, input int unsigned k, input int unsigned ext,
                            input int unsigned cnt_a, input int unsigned cnt_b);
        chk({tag, " key_a"}, 32'(key_a), k);
        chk({tag, " key_b"}, 32'(key_b), k);
        chk({tag, " is_ext_a"}, 32'(ext_a), ext);
        chk({tag, " is_ext_b"}, 32'(ext_b), ext);
        chk({tag, " is_press_a"}, 32'(press_a), 32'(k != 0));
        chk({tag, " is_press_b"}, 32'(press_b), 32'(k != 0));
        chk({tag, " count_a"}, 32'(count_a), cnt_a);
        chk({tag, " count_b"}, 32'(count_b), cnt_b);
    endtask

    task automatic chk_fifo(input string tag, input int unsigned lvl_a, input int unsigned lvl_b,
                            input int unsigned ovf);
        chk({tag, " level_a"}, 32'(level_a), lvl_a);
        chk({tag, " level_b"}, 32'(level_b), lvl_b);
        chk({tag, " out_valid_a"}, 32'(bus_a.out_valid), 32'(lvl_a != 0));
        chk({tag, " out_valid_b"}, 32'(bus_b.out_valid), 32'(lvl_b != 0));
        chk({tag, " overflow_a"}, 32'(ovf_a), ovf);
        chk({tag, " overflow_b"}, 32'(ovf_b), ovf);
    endtask

    task automatic chk_head(input string tag, input int unsigned k, input int unsigned ext,
                            input int unsigned make);
        chk({tag, " out_key_a"}, 32'(bus_a.out_key), k);
        chk({tag, " out_key_b"}, 32'(bus_b.out_key), k);
        chk({tag, " out_ext_a"}, 32'(bus_a.out_ext), ext);
        chk({tag, " out_ext_b"}, 32'(bus_b.out_ext), ext);
        chk({tag, " out_make_a"}, 32'(bus_a.out_make), make);
        chk({tag, " out_make_b"}, 32'(bus_b.out_make), make);
    endtask

    // Called at a falling edge; presents one byte for exactly one rising edge.
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset must win over a concurrent byte and pop request.
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h1C;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_held("reset", 0, 0, 0, 0);
        chk_fifo("reset", 0, 0, 0);
        rst      = 1'b1;
        in_valid = 1'b0;

        // Plain press/release, consumer always ready.
        send(8'h1C);
        chk_fifo("press", 1, 1, 0);
        chk_head("press", 'h1C, 0, 1);
        chk_held("press", 'h1C, 0, 1, 1);
        send(8'hF0);
        chk_fifo("f0", 0, 0, 0);
        send(8'h1C);
        chk_head("release", 'h1C, 0, 0);
        chk_held("release", 0, 0, 1, 1);
        @(negedge clk);

        // Extended key.
        send(8'hE0);
        send(8'h75);
        chk_head("ext press", 'h75, 1, 1);
        chk_held("ext press", 'h75, 1, 2, 2);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk_head("ext release", 'h75, 1, 0);
        chk_held("ext release", 0, 0, 2, 2);
        @(negedge clk);

        // Typematic repeat: dut_a suppresses, dut_b counts every make.
        out_ready = 1'b0;
        repeat (5) send(8'h1C);
        chk_fifo("repeat", 1, 5, 0);
        chk_held("repeat", 'h1C, 0, 3, 7);
        chk_head("repeat head", 'h1C, 0, 1);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk_fifo("repeat drained", 0, 0, 0);
        send(8'hF0);
        send(8'h1C);
        @(negedge clk);

        // Fill, push+pop while full, then overflow.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h15 + 8'(i));
        chk_fifo("full", 8, 8, 0);
        chk_held("full", 'h1C, 0, 11, 15);
        chk_head("full head", 'h15, 0, 1);
        send(8'hF0);
        out_ready = 1'b1;
        send(8'h1C);
        out_ready = 1'b0;
        chk_fifo("pushpop full", 8, 8, 0);
        chk_held("pushpop full", 0, 0, 11, 15);
        send(8'h1D);
        chk_fifo("overflow", 8, 8, 1);
        chk_held("overflow", 'h1D, 0, 12, 16);
        for (int i = 0; i < 8; i++) begin
            chk_head($sformatf("drain%0d", i), drain_key[i], 0, drain_make[i]);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk_fifo("drained", 0, 0, 1);

        // Count wrap on the 4-bit counter: 12 + 5 = 17 -> 1.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(8'h21 + 8'(i));
            send(8'hF0);
            send(8'h21 + 8'(i));
        end
        repeat (2) @(negedge clk);
        chk_held("wrap", 0, 0, 1, 21);
        chk_fifo("wrap", 0, 0, 1);

        // Reset in the middle of an E0 F0 sequence discards the prefix.
        send(8'hE0);
        send(8'hF0);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h75;
        @(negedge clk);
        chk_held("mid reset", 0, 0, 0, 0);
        chk_fifo("mid reset", 0, 0, 0);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        send(8'h75);
        chk_fifo("after reset", 1, 1, 0);
        chk_head("after reset", 'h75, 0, 1);
        chk_held("after reset", 'h75, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
